// File: rtl/alloc144_if.sv
// Allocation/free bus of the 144-entry index allocator.
// Handshake: a grant happens on any rising edge where alloc_req and alloc_rdy are both 1;
// alloc_idx is stable while alloc_rdy is 1, and alloc_req with alloc_rdy = 0 is simply dropped.
interface alloc144_if;
  logic       alloc_req;
  logic       alloc_rdy;
  logic [7:0] alloc_idx;
  logic       free_v;
  logic [7:0] free_idx;
  logic [7:0] free_cnt;
  logic       err;
  logic       fsm_state;

  modport master (
    output alloc_req, free_v, free_idx,
    input  alloc_rdy, alloc_idx, free_cnt, err, fsm_state
  );

  modport slave (
    input  alloc_req, free_v, free_idx,
    output alloc_rdy, alloc_idx, free_cnt, err, fsm_state
  );
endinterface

// File: rtl/alloc144.sv
// Lowest-index-first allocator over 144 entries with a free bitmap, popcount counter
// and an error pulse on illegal frees. Optional reserved entry 0.
module alloc144 #(
  parameter bit RSVD0 = 1'b0
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      clr,
  alloc144_if.slave bus
);
  typedef enum logic {SCAN = 1'b0, READY = 1'b1} state_t;

  localparam logic [143:0] MAP_INIT = RSVD0 ? {{143{1'b1}}, 1'b0} : {144{1'b1}};
  localparam logic [7:0]   CNT_INIT = RSVD0 ? 8'd143 : 8'd144;

  state_t       state, state_n;
  logic [143:0] map, map_n;
  logic [7:0]   cnt, cnt_n;
  logic [7:0]   idx;
  logic [7:0]   cand;
  logic         err_q;
  logic         grant, free_ok, free_bad;

  // Reverse scan so the lowest set bit is the last assignment to win.
  always_comb begin
    cand = 8'd255;
    for (int i = 143; i >= 0; i--) begin
      if (map[i]) cand = 8'(i);
    end
  end

  // A free of the entry being granted sees its map bit still set, so it is a double free.
  always_comb begin
    grant    = (state == READY) && bus.alloc_req;
    free_ok  = bus.free_v && (bus.free_idx < 8'd144) && !map[bus.free_idx]
               && !(RSVD0 && (bus.free_idx == 8'd0));
    free_bad = bus.free_v && !free_ok;
    map_n    = map;
    if (grant)   map_n[idx] = 1'b0;
    if (free_ok) map_n[bus.free_idx] = 1'b1;
    cnt_n    = cnt + 8'(free_ok) - 8'(grant);
  end

  always_comb begin
    state_n = state;
    case (state)
      SCAN:    if (cand != 8'd255) state_n = READY;
      READY:   if (grant) state_n = SCAN;
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn)    state <= SCAN;
    else if (clr) state <= SCAN;
    else          state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      map   <= MAP_INIT;
      cnt   <= CNT_INIT;
      idx   <= 8'd255;
      err_q <= 1'b0;
    end else if (clr) begin
      map   <= MAP_INIT;
      cnt   <= CNT_INIT;
      idx   <= 8'd255;
      err_q <= 1'b0;
    end else begin
      map   <= map_n;
      cnt   <= cnt_n;
      err_q <= free_bad;
      // Candidate is sampled only in SCAN; later lower frees wait for the next scan.
      if (state == SCAN) idx <= cand;
    end
  end

  assign bus.alloc_rdy = (state == READY) && !clr;
  assign bus.alloc_idx = idx;
  assign bus.free_cnt  = cnt;
  assign bus.err       = err_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_alloc144.sv
// Directed bench for alloc144: one default instance and one with entry 0 reserved.
module tb_alloc144;
  logic clk = 1'b0;
  logic rstn0, rstn1, clr0, clr1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alloc144_if bus0();
  alloc144_if bus1();

  alloc144 #(.RSVD0(1'b0)) dut0 (.clk(clk), .rstn(rstn0), .clr(clr0), .bus(bus0.slave));
  alloc144 #(.RSVD0(1'b1)) dut1 (.clk(clk), .rstn(rstn1), .clr(clr1), .bus(bus1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    bus0.alloc_req = 1'b0; bus0.free_v = 1'b0; bus0.free_idx = 8'd0;
    bus1.alloc_req = 1'b0; bus1.free_v = 1'b0; bus1.free_idx = 8'd0;
    tick(); tick();

    check("rst_rdy", 8'(bus0.alloc_rdy), 8'd0);
    check("rst_idx", bus0.alloc_idx, 8'd255);
    check("rst_cnt", bus0.free_cnt, 8'd144);
    check("rst_err", 8'(bus0.err), 8'd0);

    rstn0 = 1'b1;
    tick();
    check("first_rdy", 8'(bus0.alloc_rdy), 8'd1);
    check("first_idx", bus0.alloc_idx, 8'd0);

    // Held request: grants 0, 1, 2 on alternate edges.
    bus0.alloc_req = 1'b1;
    tick(); check("g0_rdy", 8'(bus0.alloc_rdy), 8'd0); check("g0_cnt", bus0.free_cnt, 8'd143);
    check("g0_err", 8'(bus0.err), 8'd0);
    tick(); check("s1_rdy", 8'(bus0.alloc_rdy), 8'd1); check("s1_idx", bus0.alloc_idx, 8'd1);
    tick(); check("g1_cnt", bus0.free_cnt, 8'd142); check("g1_err", 8'(bus0.err), 8'd0);
    tick(); check("s2_idx", bus0.alloc_idx, 8'd2);
    tick(); check("g2_cnt", bus0.free_cnt, 8'd141); check("g2_rdy", 8'(bus0.alloc_rdy), 8'd0);
    check("g2_err", 8'(bus0.err), 8'd0);
    bus0.alloc_req = 1'b0;
    tick(); check("s3_idx", bus0.alloc_idx, 8'd3); check("s3_rdy", 8'(bus0.alloc_rdy), 8'd1);

    // Double free of a free entry, then out-of-range free.
    bus0.free_v = 1'b1; bus0.free_idx = 8'd5;
    tick(); bus0.free_v = 1'b0;
    check("dbl_err", 8'(bus0.err), 8'd1); check("dbl_cnt", bus0.free_cnt, 8'd141);
    tick(); check("dbl_err_end", 8'(bus0.err), 8'd0);
    bus0.free_v = 1'b1; bus0.free_idx = 8'd150;
    tick(); bus0.free_v = 1'b0;
    check("oor_err", 8'(bus0.err), 8'd1); check("oor_cnt", bus0.free_cnt, 8'd141);
    tick(); check("oor_err_end", 8'(bus0.err), 8'd0);
    check("oor_idx", bus0.alloc_idx, 8'd3);

    // Grant 3, then grant 4 with a same-cycle free of 3.
    bus0.alloc_req = 1'b1;
    tick(); bus0.alloc_req = 1'b0; check("g3_cnt", bus0.free_cnt, 8'd140);
    tick(); check("s4_idx", bus0.alloc_idx, 8'd4);
    bus0.alloc_req = 1'b1; bus0.free_v = 1'b1; bus0.free_idx = 8'd3;
    tick(); bus0.alloc_req = 1'b0; bus0.free_v = 1'b0;
    check("gf_cnt", bus0.free_cnt, 8'd140); check("gf_err", 8'(bus0.err), 8'd0);
    tick(); check("gf_next", bus0.alloc_idx, 8'd3);
    // Grant 3 while returning 4, so 4 becomes the candidate again.
    bus0.alloc_req = 1'b1; bus0.free_v = 1'b1; bus0.free_idx = 8'd4;
    tick(); bus0.alloc_req = 1'b0; bus0.free_v = 1'b0;
    check("gf2_cnt", bus0.free_cnt, 8'd140);
    tick(); check("s4b_idx", bus0.alloc_idx, 8'd4);
    // Free of the very entry being granted.
    bus0.alloc_req = 1'b1; bus0.free_v = 1'b1; bus0.free_idx = 8'd4;
    tick(); bus0.alloc_req = 1'b0; bus0.free_v = 1'b0;
    check("gsame_err", 8'(bus0.err), 8'd1); check("gsame_cnt", bus0.free_cnt, 8'd139);
    check("gsame_rdy", 8'(bus0.alloc_rdy), 8'd0);
    tick(); check("gsame_err_end", 8'(bus0.err), 8'd0); check("s5_idx", bus0.alloc_idx, 8'd5);

    // Drain the remaining entries 5..143.
    for (int i = 5; i < 144; i++) begin
      check("drain_rdy", 8'(bus0.alloc_rdy), 8'd1);
      check("drain_idx", bus0.alloc_idx, 8'(i));
      bus0.alloc_req = 1'b1;
      tick(); bus0.alloc_req = 1'b0;
      tick();
    end
    check("empty_rdy", 8'(bus0.alloc_rdy), 8'd0);
    check("empty_idx", bus0.alloc_idx, 8'd255);
    check("empty_cnt", bus0.free_cnt, 8'd0);
    bus0.alloc_req = 1'b1;
    tick(); bus0.alloc_req = 1'b0;
    check("empty_req_cnt", bus0.free_cnt, 8'd0);

    bus0.free_v = 1'b1; bus0.free_idx = 8'd77;
    tick(); bus0.free_v = 1'b0;
    check("f77_cnt", bus0.free_cnt, 8'd1); check("f77_rdy0", 8'(bus0.alloc_rdy), 8'd0);
    check("f77_err", 8'(bus0.err), 8'd0);
    tick(); check("f77_rdy", 8'(bus0.alloc_rdy), 8'd1); check("f77_idx", bus0.alloc_idx, 8'd77);

    // A lower free while READY must not move the held candidate.
    bus0.free_v = 1'b1; bus0.free_idx = 8'd10;
    tick(); bus0.free_v = 1'b0;
    check("low_hold_idx", bus0.alloc_idx, 8'd77); check("low_cnt", bus0.free_cnt, 8'd2);
    bus0.alloc_req = 1'b1;
    tick(); bus0.alloc_req = 1'b0;
    tick(); check("low_next", bus0.alloc_idx, 8'd10); check("low_cnt2", bus0.free_cnt, 8'd1);

    // Flush with a same-cycle grant and illegal free: both discarded, no err.
    clr0 = 1'b1; bus0.alloc_req = 1'b1; bus0.free_v = 1'b1; bus0.free_idx = 8'd200;
    tick(); clr0 = 1'b0; bus0.alloc_req = 1'b0; bus0.free_v = 1'b0;
    check("clr_cnt", bus0.free_cnt, 8'd144); check("clr_rdy", 8'(bus0.alloc_rdy), 8'd0);
    check("clr_err", 8'(bus0.err), 8'd0);
    tick(); check("clr_next", bus0.alloc_idx, 8'd0);

    for (int i = 0; i < 10; i++) begin
      check("ten_idx", bus0.alloc_idx, 8'(i));
      bus0.alloc_req = 1'b1;
      tick(); bus0.alloc_req = 1'b0;
      tick();
    end
    check("ten_cnt", bus0.free_cnt, 8'd134);
    clr0 = 1'b1; bus0.alloc_req = 1'b1;
    tick(); clr0 = 1'b0; bus0.alloc_req = 1'b0;
    check("clr2_cnt", bus0.free_cnt, 8'd144); check("clr2_rdy", 8'(bus0.alloc_rdy), 8'd0);
    tick(); check("clr2_next", bus0.alloc_idx, 8'd0);

    // Reset mid-grant overrides the grant and a free.
    bus0.alloc_req = 1'b1;
    tick(); bus0.alloc_req = 1'b0;
    tick(); check("pre_rst_idx", bus0.alloc_idx, 8'd1); check("pre_rst_cnt", bus0.free_cnt, 8'd143);
    rstn0 = 1'b0; bus0.alloc_req = 1'b1; bus0.free_v = 1'b1; bus0.free_idx = 8'd0;
    tick(); rstn0 = 1'b1; bus0.alloc_req = 1'b0; bus0.free_v = 1'b0;
    check("mrst_cnt", bus0.free_cnt, 8'd144); check("mrst_rdy", 8'(bus0.alloc_rdy), 8'd0);
    check("mrst_idx", bus0.alloc_idx, 8'd255); check("mrst_err", 8'(bus0.err), 8'd0);
    tick(); check("mrst_next", bus0.alloc_idx, 8'd0); check("mrst_rdy1", 8'(bus0.alloc_rdy), 8'd1);

    // Reserved entry 0 instance.
    check("r_rst_cnt", bus1.free_cnt, 8'd143);
    check("r_rst_idx", bus1.alloc_idx, 8'd255);
    rstn1 = 1'b1;
    tick(); check("r_first_idx", bus1.alloc_idx, 8'd1); check("r_first_rdy", 8'(bus1.alloc_rdy), 8'd1);
    bus1.alloc_req = 1'b1;
    tick(); bus1.alloc_req = 1'b0;
    check("r_g1_cnt", bus1.free_cnt, 8'd142);
    bus1.free_v = 1'b1; bus1.free_idx = 8'd0;
    tick(); bus1.free_v = 1'b0;
    check("r_f0_err", 8'(bus1.err), 8'd1); check("r_f0_cnt", bus1.free_cnt, 8'd142);
    check("r_next_idx", bus1.alloc_idx, 8'd2);
    tick(); check("r_f0_err_end", 8'(bus1.err), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alloc144.md
ALLOC144 -- requirements
Module: alloc144

Interface
REQ-001 Parameter RSVD0, default 0; when 1, entry 0 is never free and is never allocated.
REQ-002 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port rstn, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-004 Port clr, input, 1, synchronous flush; returns every entry to free.
REQ-005 Port alloc_req, input, 1, consumer requests one entry.
REQ-006 Port alloc_rdy, output, 1, alloc_idx holds a valid free entry.
REQ-007 Port alloc_idx, output, 8, granted index, 0..143; 8'd255 when none available.
REQ-008 Port free_v, input, 1, return of one entry this cycle.
REQ-009 Port free_idx, input, 8, index being returned.
REQ-010 Port free_cnt, output, 8, number of free entries, 0..144.
REQ-011 Port err, output, 1, one-cycle pulse on an illegal free.

Function
REQ-012 Block SHALL hold a 144-bit free map; bit n = 1 means entry n is free.
REQ-013 Candidate SHALL be the lowest-index set bit of the free map, 8'd255 when the map is zero.
REQ-014 State machine SHALL have states SCAN and READY.
REQ-015 SCAN: register candidate into alloc_idx; next state READY if candidate != 255, else stay SCAN; alloc_rdy = 0.
REQ-016 READY: alloc_rdy = 1; alloc_idx held stable until grant.
REQ-017 Grant SHALL occur on a clock edge with alloc_req = 1 and alloc_rdy = 1; map bit alloc_idx cleared, free_cnt decremented, next state SCAN.
REQ-018 Throughput SHALL be at most one grant per two cycles; alloc_req while alloc_rdy = 0 is ignored (no queueing).
REQ-019 Legal free (free_v = 1, free_idx < 144, map bit = 0, not reserved entry 0 when RSVD0 = 1) SHALL set the map bit and increment free_cnt on the same edge.
REQ-020 Illegal free (index >= 144, bit already free, or reserved entry 0) SHALL leave map and free_cnt unchanged and pulse err for exactly the following cycle.
REQ-021 Free of an index lower than a held candidate in READY SHALL NOT disturb alloc_idx; lowest-first is only guaranteed at SCAN time.
REQ-022 Simultaneous grant and legal free of a different index SHALL leave free_cnt unchanged and update both map bits.
REQ-023 Free of the index being granted in the same cycle SHALL be treated as a double free: grant proceeds and err pulses.
REQ-024 Freeing while in SCAN with an empty map SHALL make the freed index the candidate on the next SCAN edge.
REQ-025 free_cnt SHALL never wrap; it equals the popcount of the free map at all times.
REQ-026 clr = 1 SHALL set the map to all free (bit 0 clear if RSVD0), load free_cnt, force SCAN, drive alloc_rdy = 0, and discard any same-cycle grant or free; err is not raised.

Reset
REQ-027 While rstn = 0 at an edge: map all ones (bit 0 = 0 if RSVD0), free_cnt = 144 (143 if RSVD0), state SCAN, alloc_rdy = 0, alloc_idx = 8'd255, err = 0.
REQ-028 First edge after rstn rises SHALL load alloc_idx = 0 (1 if RSVD0) and enter READY; alloc_rdy = 1 in the following cycle.
REQ-029 Reset asserted mid-operation SHALL override grant, free and clr on the same edge.

Verification
REQ-030 Reset, hold alloc_req high -> grants 0, 1, 2 on alternate cycles; free_cnt 141; err never pulses.
REQ-031 Allocate all 144 -> alloc_rdy 0, alloc_idx 255, free_cnt 0; free 77 -> two edges later alloc_rdy 1, alloc_idx 77, free_cnt 1.
REQ-032 Free index 5 while still free, then free index 150 -> err pulses once per event, free_cnt unchanged.
REQ-033 Grant of index 4 with same-cycle free of allocated index 3 -> free_cnt unchanged, next candidate 3; same-cycle free of 4 instead -> err, grant of 4 stands.
REQ-034 RSVD0 = 1, reset -> free_cnt 143, first grant 1; free_idx 0 -> err.
REQ-035 After 10 grants assert clr, then separately rstn = 0 mid-grant -> free_cnt 144, alloc_rdy 0, next grant 0.
